// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package instr_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
  localparam int unsigned INSTR_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module byte_packer
  import instr_loader_pkg::*;
#(
  parameter int unsigned WORD_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned IDX_W = $clog2(BYTES);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] shreg;

  // word_full flags the accept that completes a word; word already includes that byte.
  assign word_full = accept && (idx == IDX_W'(BYTES - 1));

  always_comb begin
    word = shreg;
    if (accept) begin
      word[{idx, 3'b000} +: 8] = in_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (accept) begin
      idx                      <= idx + IDX_W'(1);
      shreg[{idx, 3'b000} +: 8] <= in_byte;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams bytes into 32-bit instruction words and writes them into instruction memory,
// holding the CPU while a load runs and reporting a running word checksum.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(IMEM_DEPTH);

  loader_state_e     state, state_next;
  logic              accept, word_full, clear;
  logic              start_load, start_zero, capture, write_fire;
  logic [DATA_W-1:0] packed_word;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   count_q;

  assign in_ready = (state == RECV);
  assign accept   = in_ready && in_valid;
  assign busy     = (state == RECV) || (state == WRITE);
  assign cpu_hold = busy;
  assign done     = (state == DONE);
  assign mem_we   = write_fire;
  assign clear    = abort || start_load;

  byte_packer #(
    .WORD_W(DATA_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .accept   (accept),
    .in_byte  (in_data),
    .word_full(word_full),
    .word     (packed_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_load = 1'b0;
    start_zero = 1'b0;
    capture    = 1'b0;
    write_fire = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (word_count == '0) begin
              start_zero = 1'b1;
              state_next = DONE;
            end else begin
              start_load = 1'b1;
              state_next = RECV;
            end
          end
        end
        RECV: begin
          if (word_full) begin
            capture    = 1'b1;
            state_next = WRITE;
          end
        end
        WRITE: begin
          write_fire = 1'b1;
          state_next = ((words_written + 1'b1) == count_q) ? DONE : RECV;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // mem_addr/mem_wdata are captured with the completing byte so they are valid during
  // WRITE and keep their values afterwards, while cur_addr advances independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr      <= '0;
      count_q       <= '0;
      words_written <= '0;
      checksum      <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      if (start_load || start_zero) begin
        words_written <= '0;
        checksum      <= '0;
        cur_addr      <= start_addr;
        count_q       <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
      end
      if (capture) begin
        mem_addr  <= cur_addr;
        mem_wdata <= packed_word;
      end
      if (write_fire) begin
        checksum      <= checksum + mem_wdata;
        words_written <= words_written + 1'b1;
        cur_addr      <= cur_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven loads plus corner-case sequences,
// with a write scoreboard fed by the stimulus and drained by observed mem_we strobes.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [7:0]  start_addr, in_data;
  logic [8:0]  word_count;
  logic        in_ready, mem_we, cpu_hold, busy, done;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [8:0]  words_written;

  int checks   = 0;
  int failures = 0;

  logic [39:0] exp_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [8:0]  count;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          stall;
    logic [8:0]  exp_ww;
    logic [31:0] exp_cks;
  } vec_t;

  vec_t vecs[4];

  instr_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .word_count   (word_count),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .words_written(words_written),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_addr, mem_wdata[23:0]}, 32'h0);
        check("unexpected_we", 32'(mem_we), 32'h0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("sb_addr", 32'(mem_addr), 32'(e[39:32]));
        check("sb_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_start(input logic [7:0] a, input logic [8:0] n);
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  // Sends one word's four bytes; returns one cycle after the last byte (in WRITE).
  task automatic send_word(input logic [31:0] w, input bit stall, input logic [7:0] a);
    exp_q.push_back({a, w});
    for (int k = 0; k < 4; k++) begin
      if (stall) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = w[8*k +: 8];
      tick();
    end
    in_valid = 1'b0;
    check("write_latency_we", 32'(mem_we), 32'h1);
    check("write_addr", 32'(mem_addr), 32'(a));
    check("write_data", mem_wdata, w);
  endtask

  initial begin
    logic [31:0] w, sum;
    logic [7:0]  a;

    vecs[0] = '{addr: 8'h00, count: 9'd1, w0: 32'h0010_0513, w1: 32'h0,
                stall: 1'b0, exp_ww: 9'd1, exp_cks: 32'h0010_0513};
    vecs[1] = '{addr: 8'hFF, count: 9'd2, w0: 32'h0000_0001, w1: 32'hFFFF_FFFF,
                stall: 1'b1, exp_ww: 9'd2, exp_cks: 32'h0000_0000};
    vecs[2] = '{addr: 8'h10, count: 9'd2, w0: 32'h1234_5678, w1: 32'h9ABC_DEF0,
                stall: 1'b0, exp_ww: 9'd2, exp_cks: 32'hACF1_3568};
    vecs[3] = '{addr: 8'h80, count: 9'd0, w0: 32'h0, w1: 32'h0,
                stall: 1'b0, exp_ww: 9'd0, exp_cks: 32'h0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; start_addr = '0; word_count = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_words", 32'(words_written), 32'h0);
    check("rst_checksum", checksum, 32'h0);

    for (int i = 0; i < 4; i++) begin
      do_start(vecs[i].addr, vecs[i].count);
      if (vecs[i].count != 0) begin
        check("tbl_busy", 32'(busy), 32'h1);
        check("tbl_cpu_hold", 32'(cpu_hold), 32'h1);
        for (int j = 0; j < int'(vecs[i].count); j++) begin
          w = (j == 0) ? vecs[i].w0 : vecs[i].w1;
          a = vecs[i].addr + 8'(j);
          send_word(w, vecs[i].stall, a);
          tick();
        end
      end
      check("tbl_done", 32'(done), 32'h1);
      check("tbl_cpu_hold_low", 32'(cpu_hold), 32'h0);
      check("tbl_words", 32'(words_written), 32'(vecs[i].exp_ww));
      check("tbl_checksum", checksum, vecs[i].exp_cks);
    end

    // Oversize count clamps to a full 256-word image with address wrap.
    do_start(8'h40, 9'd300);
    sum = '0;
    for (int i = 0; i < 256; i++) begin
      w = 32'(i) * 32'h0101_0101 + 32'h0F00_0001;
      send_word(w, 1'b0, 8'h40 + 8'(i));
      tick();
      sum = sum + w;
    end
    check("big_done", 32'(done), 32'h1);
    check("big_words", 32'(words_written), 32'd256);
    check("big_checksum", checksum, sum);
    check("big_last_addr", 32'(mem_addr), 32'h3F);
    repeat (3) tick();

    // Abort partway through the second word.
    do_start(8'h20, 9'd3);
    send_word(32'hAAAA_5555, 1'b0, 8'h20);
    tick();
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_words", 32'(words_written), 32'h1);
    check("abort_checksum", checksum, 32'hAAAA_5555);
    repeat (6) tick();
    do_start(8'h30, 9'd1);
    send_word(32'h0102_0304, 1'b0, 8'h30);
    tick();
    check("reload_done", 32'(done), 32'h1);
    check("reload_checksum", checksum, 32'h0102_0304);

    // start during RECV is ignored.
    do_start(8'h50, 9'd1);
    exp_q.push_back({8'h50, 32'hCAFE_F00D});
    in_valid = 1'b1; in_data = 8'h0D; tick();
    in_data = 8'hF0; tick();
    in_valid = 1'b0;
    start = 1'b1; start_addr = 8'h99; word_count = 9'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hFE; tick();
    in_data = 8'hCA; tick();
    in_valid = 1'b0;
    check("coll_we", 32'(mem_we), 32'h1);
    tick();
    check("coll_done", 32'(done), 32'h1);
    check("coll_words", 32'(words_written), 32'h1);

    // abort beats start from DONE.
    start = 1'b1; abort = 1'b1; start_addr = 8'h70; word_count = 9'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abst_done", 32'(done), 32'h0);
    check("abst_busy", 32'(busy), 32'h0);
    check("abst_words", 32'(words_written), 32'h1);
    check("abst_checksum", checksum, 32'hCAFE_F00D);

    // Reset during WRITE.
    do_start(8'h60, 9'd2);
    send_word(32'h7654_3210, 1'b0, 8'h60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_we", 32'(mem_we), 32'h0);
    check("rstw_busy", 32'(busy), 32'h0);
    check("rstw_mem_addr", 32'(mem_addr), 32'h0);
    check("rstw_mem_wdata", mem_wdata, 32'h0);
    check("rstw_words", 32'(words_written), 32'h0);
    check("rstw_checksum", checksum, 32'h0);
    repeat (4) tick();

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side counterpart of the 256 x 32-bit instruction memory.
- Accepts a byte stream from a host-side source (UART receiver or testbench), assembles little-endian 32-bit instruction words, and issues one-cycle write strobes into the instruction memory write port.
- Holds the CPU stalled while a load is in progress.
- Reports completion and a running word checksum so the host can confirm the image.

Parameters:
- ADDR_W, 8, instruction memory address width (depth = 2**ADDR_W = 256 words).
- DATA_W, 32, instruction word width; must be 32 (4 bytes per word).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load.
- start_addr  input  8  first word address of the load.
- word_count  input  9  number of words to load, 0..256.
- abort  input  1  cancel the current load.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  8  write address.
- mem_wdata  output  32  write data.
- cpu_hold  output  1  stall or hold the CPU (high during load).
- busy  output  1  load in progress.
- done  output  1  last load completed.
- words_written  output  9  words written in current/last load.
- checksum  output  32  sum mod 2^32 of all words written in current/last load.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - in_ready, mem_we, cpu_hold, busy and done are all 0.
  - mem_addr, mem_wdata, words_written and checksum are all 0.
  - Internal byte index is 0.
  - Reset mid-load abandons the load immediately; words already written stay in memory.
- States: IDLE, RECV, WRITE, DONE.
- IDLE / DONE:
  - start=1 with word_count=0: go to DONE next cycle.
    - words_written=0, checksum=0, done=1, no write.
  - start=1 with word_count>=1: latch the count and go to RECV.
    - Counts above 256 are clamped to 256.
    - Latch start_addr as the current address.
    - Clear words_written, checksum, byte index and done.
  - done stays 1 in DONE until the next start, abort or rst.
- RECV:
  - in_ready=1, busy=1, cpu_hold=1.
  - A byte is accepted only when in_valid & in_ready are both 1 at a clk edge.
  - Byte k (k=0..3) goes to word bits [8k+7:8k], little-endian; byte 0 is the LSB.
  - On the 4th accepted byte, go to WRITE.
  - Cycles with in_valid=0 are stalls; the partial word is kept.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=current address, mem_wdata=assembled word, in_ready=0.
  - At the end of the cycle:
    - checksum += word (mod 2^32), words_written += 1.
    - Address += 1 mod 256; the address wraps from 255 to 0.
  - If words_written reaches the latched count, go to DONE; otherwise return to RECV.
- Throughput: at most one word per 5 cycles (4 byte cycles + 1 write cycle).
  - The first mem_we occurs 1 cycle after the 4th byte is accepted.
- Outside WRITE:
  - mem_we=0.
  - mem_addr and mem_wdata hold their last values.
- start while in RECV or WRITE: ignored.
- abort=1 in any state:
  - Next state is IDLE; in_ready, mem_we, busy, cpu_hold and done all go to 0.
  - The partial word is discarded.
  - words_written and checksum keep their last values.
  - abort during WRITE suppresses that write (mem_we=0 that cycle).
- Priority when asserted in the same cycle: rst > abort > start.
- cpu_hold = busy, combinational from state (high in RECV and WRITE).

Decomposition:
- Shared package:
  - IMEM_ADDR_W=8, IMEM_DEPTH=256, INSTR_W=32.
  - Loader state enum {IDLE, RECV, WRITE, DONE}.
- One natural sub-module: byte_packer.
  - Contains the byte index counter and the 4-byte little-endian assembly register.
  - Interface: clear, accept, byte in, word_full, word out.
- The FSM, address counter and checksum stay in instr_loader.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then hold inputs low for 10 cycles -> all outputs 0, state IDLE, in_ready=0.
- Single word: start, start_addr=0x00, word_count=1; bytes 0x13,0x05,0x10,0x00 back-to-back -> one mem_we pulse 1 cycle after the 4th byte, mem_addr=0x00, mem_wdata=0x00100513; then done=1, words_written=1, checksum=0x00100513, cpu_hold falls.
- Stalled stream with wrap: start_addr=0xFF, word_count=2; in_valid toggled 1/0 every cycle; words 0x00000001 and 0xFFFFFFFF -> writes at 0xFF then 0x00; checksum=0x00000000 (wrap); no byte lost or duplicated.
- Zero and oversize counts: word_count=0 -> done=1 one cycle after start, no mem_we. word_count=300 -> exactly 256 writes covering addresses start_addr..start_addr+255 mod 256.
- Abort mid-word: word_count=3, abort after 2 bytes of word 1 -> no further mem_we, state IDLE, words_written=1. A new start then loads cleanly from byte index 0.
- Collisions:
  - start asserted during RECV -> ignored.
  - abort and start in the same cycle from DONE -> IDLE, done=0.
  - rst asserted during WRITE -> mem_we=0 on the next cycle, all outputs at reset values.
